// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: operand forwarding selects,
// stall/flush generation, HI/LO busy counter and data-memory handshake FSM.
module hazard_ctrl #(
    parameter int unsigned MULT_LAT   = 4,
    parameter int unsigned DIV_LAT    = 32,
    parameter int unsigned DELAY_SLOT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       JumpRD,
    input  logic       PCSrcD,
    input  logic       MDOpD,
    input  logic       HiLoReadD,
    input  logic       MDStartE,
    input  logic       MDIsDivE,
    input  logic       MemReqM,
    input  logic       MemAckM,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       MDGoE,
    output logic       MDBusy,
    output logic       MemStrobeM
);

    localparam int unsigned CW = $clog2(DIV_LAT + 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } mem_state_e;

    logic [CW-1:0] count_q, count_d;
    mem_state_e    state_q, state_d;

    logic lwstall, branchstall, mdstall, dstall, memstall;
    logic e_hit, m_hit;

    // Register 0 is hard-wired, so a match on it is never a dependency.
    function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic wm,
                                           input logic [4:0] dm, input logic ww,
                                           input logic [4:0] dw);
        if (wm && reg_hit(dm, src))      return 2'b10;
        else if (ww && reg_hit(dw, src)) return 2'b01;
        else                             return 2'b00;
    endfunction

    always_comb begin
        ForwardAE = fwd_sel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        ForwardBE = fwd_sel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
        ForwardAD = RegWriteM && reg_hit(WriteRegM, RsD);
        ForwardBD = RegWriteM && reg_hit(WriteRegM, RtD);
    end

    always_comb begin
        lwstall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
        // jr/jalr only reads Rs; conditional branches read both sources.
        e_hit = RegWriteE && ((BranchD && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD)))
                           || (JumpRD && reg_hit(WriteRegE, RsD)));
        m_hit = MemtoRegM && ((BranchD && (reg_hit(WriteRegM, RsD) || reg_hit(WriteRegM, RtD)))
                           || (JumpRD && reg_hit(WriteRegM, RsD)));
        branchstall = e_hit || m_hit;
    end

    always_comb begin
        state_d    = state_q;
        memstall   = 1'b0;
        MemStrobeM = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (MemReqM) begin
                    MemStrobeM = 1'b1;
                    memstall   = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                memstall = !MemAckM;
                if (MemAckM) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        MDBusy  = (count_q != '0);
        MDGoE   = MDStartE && !memstall && (count_q == '0);
        mdstall = (HiLoReadD || MDOpD) && (MDBusy || MDStartE);
        count_d = count_q;
        if (MDGoE)
            count_d = MDIsDivE ? CW'(DIV_LAT) : CW'(MULT_LAT);
        else if (MDBusy)
            count_d = count_q - CW'(1);
    end

    always_comb begin
        dstall = lwstall || branchstall || mdstall;
        StallF = dstall || memstall;
        StallD = dstall || memstall;
        StallE = memstall;
        StallM = memstall;
        FlushW = memstall;
        // E is held under memstall, so a bubble there would drop a live instruction.
        FlushE = dstall && !memstall;
        FlushD = (DELAY_SLOT == 0) && PCSrcD && !StallD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            state_q <= S_IDLE;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random stimulus,
// each cycle's expected outputs come from a cycle-count based reference model.
module tb_hazard_ctrl;

    localparam int unsigned MULT_LAT = 4;
    localparam int unsigned DIV_LAT  = 32;

    typedef struct packed {
        logic       rst;
        logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
        logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
        logic       BranchD, JumpRD, PCSrcD, MDOpD, HiLoReadD;
        logic       MDStartE, MDIsDivE, MemReqM, MemAckM;
    } stim_t;

    // Order: FwdAD FwdBD FwdAE FwdBE StallF StallD StallE StallM FlushD FlushE FlushW MDGoE MDBusy MemStrobeM
    typedef logic [17:0] resp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, JumpRD, PCSrcD, MDOpD, HiLoReadD;
    logic       MDStartE, MDIsDivE, MemReqM, MemAckM;
    logic       ForwardAD, ForwardBD;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic       MDGoE, MDBusy, MemStrobeM;

    hazard_ctrl #(
        .MULT_LAT  (MULT_LAT),
        .DIV_LAT   (DIV_LAT),
        .DELAY_SLOT(0)
    ) dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .BranchD(BranchD), .JumpRD(JumpRD), .PCSrcD(PCSrcD),
        .MDOpD(MDOpD), .HiLoReadD(HiLoReadD), .MDStartE(MDStartE), .MDIsDivE(MDIsDivE),
        .MemReqM(MemReqM), .MemAckM(MemAckM),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MDGoE(MDGoE), .MDBusy(MDBusy), .MemStrobeM(MemStrobeM)
    );

    resp_t act;
    assign act = {ForwardAD, ForwardBD, ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                  FlushD, FlushE, FlushW, MDGoE, MDBusy, MemStrobeM};

    resp_t exp_q[$];
    int    tag_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    drv_done = 1'b0;

    // Reference model state: HI/LO unit is busy while cyc < busy_until.
    int    cyc = 0;
    int    busy_until = 0;
    bit    mem_wait = 1'b0;
    stim_t cur = '0;
    bit    cur_go = 1'b0;

    function automatic bit dep(input logic [4:0] dst, input logic [4:0] src);
        return dst != 0 && dst == src;
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] src, input stim_t s);
        if (s.RegWriteM && dep(s.WriteRegM, src)) return 2'd2;
        if (s.RegWriteW && dep(s.WriteRegW, src)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic resp_t model(input stim_t s);
        bit busy, ms, lw, br, md, ds, go, sd, reads_rt;
        busy = cyc < busy_until;
        ms   = mem_wait ? !s.MemAckM : s.MemReqM;
        lw   = s.MemtoRegE && s.RtE != 0 && (s.RtE == s.RsD || s.RtE == s.RtD);
        reads_rt = s.BranchD;
        br   = 0;
        if (s.BranchD || s.JumpRD) begin
            br = (s.RegWriteE && (dep(s.WriteRegE, s.RsD) || (reads_rt && dep(s.WriteRegE, s.RtD))))
              || (s.MemtoRegM && (dep(s.WriteRegM, s.RsD) || (reads_rt && dep(s.WriteRegM, s.RtD))));
        end
        md   = (s.HiLoReadD || s.MDOpD) && (busy || s.MDStartE);
        ds   = lw || br || md;
        go   = s.MDStartE && !ms && !busy;
        sd   = ds || ms;
        return {s.RegWriteM && dep(s.WriteRegM, s.RsD), s.RegWriteM && dep(s.WriteRegM, s.RtD),
                fsel(s.RsE, s), fsel(s.RtE, s), sd, sd, ms, ms,
                s.PCSrcD && !sd, ds && !ms, ms, go, busy, !mem_wait && s.MemReqM};
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; RsD = s.RsD; RtD = s.RtD; RsE = s.RsE; RtE = s.RtE;
        WriteRegE = s.WriteRegE; WriteRegM = s.WriteRegM; WriteRegW = s.WriteRegW;
        RegWriteE = s.RegWriteE; RegWriteM = s.RegWriteM; RegWriteW = s.RegWriteW;
        MemtoRegE = s.MemtoRegE; MemtoRegM = s.MemtoRegM; BranchD = s.BranchD;
        JumpRD = s.JumpRD; PCSrcD = s.PCSrcD; MDOpD = s.MDOpD; HiLoReadD = s.HiLoReadD;
        MDStartE = s.MDStartE; MDIsDivE = s.MDIsDivE; MemReqM = s.MemReqM; MemAckM = s.MemAckM;
    endtask

    task automatic step(input stim_t s);
        resp_t e;
        @(posedge clk);
        if (!cur.rst) begin
            if (cur_go) busy_until = cyc + 1 + (cur.MDIsDivE ? DIV_LAT : MULT_LAT);
            if (mem_wait) mem_wait = !cur.MemAckM;
            else          mem_wait = cur.MemReqM;
        end
        cyc++;
        #1;
        cur = s;
        apply(s);
        if (s.rst) begin
            mem_wait   = 1'b0;
            busy_until = 0;
        end
        e = model(s);
        cur_go = e[2];
        exp_q.push_back(e);
        tag_q.push_back(cyc);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                resp_t e;
                int t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL hazard_outputs cycle %0d: got %b expected %b", t, act, e);
                end
            end
        end
    end

    initial begin
        stim_t s;
        apply('0);
        rst = 1'b1;
        s = '0; s.rst = 1'b1;
        step(s); step(s);
        s = '0;
        step(s);

        // Forwarding priority M over W, then W only, then register 0.
        s = '0; s.RsE = 5; s.RegWriteM = 1; s.WriteRegM = 5; s.RegWriteW = 1; s.WriteRegW = 5;
        step(s);
        s.RegWriteM = 0; step(s);
        s.RsE = 0; step(s);

        // Load-use, then RtE = 0 must not stall.
        s = '0; s.MemtoRegE = 1; s.RtE = 8; s.RsD = 8; step(s);
        s = '0; s.RsD = 8; step(s);
        s = '0; s.MemtoRegE = 1; s.RtE = 0; s.RsD = 0; step(s);

        // Branch dependency on E, then resolved by forwarding from M; jr ignores Rt.
        s = '0; s.BranchD = 1; s.RtD = 3; s.RegWriteE = 1; s.WriteRegE = 3; step(s);
        s = '0; s.BranchD = 1; s.RtD = 3; s.RegWriteM = 1; s.WriteRegM = 3; step(s);
        s = '0; s.JumpRD = 1; s.RsD = 4; s.RtD = 3; s.RegWriteE = 1; s.WriteRegE = 3; step(s);
        s = '0; s.BranchD = 1; s.RsD = 6; s.MemtoRegM = 1; s.WriteRegM = 6; s.PCSrcD = 1; step(s);
        s = '0; s.PCSrcD = 1; step(s);

        // Divide with mfhi waiting in D, then multiply.
        s = '0; s.MDStartE = 1; s.MDIsDivE = 1; s.HiLoReadD = 1; step(s);
        s = '0; s.HiLoReadD = 1;
        for (int i = 0; i < 34; i++) step(s);
        s = '0; s.MDStartE = 1; s.MDOpD = 1; step(s);
        s = '0; s.MDOpD = 1;
        for (int i = 0; i < 6; i++) step(s);

        // Memory wait with ack in 4th cycle, load-use during the wait, then back-to-back.
        s = '0; s.MemReqM = 1; step(s);
        s.MemtoRegE = 1; s.RtE = 8; s.RsD = 8; step(s);
        s.MemtoRegE = 0; step(s);
        s.MemAckM = 1; step(s);
        s.MemAckM = 0; step(s);
        s.MemAckM = 1; step(s);
        s = '0; step(s);

        // Reset with count at 17 and memory FSM waiting; next request strobes again.
        s = '0; s.MDStartE = 1; s.MDIsDivE = 1; step(s);
        s = '0; s.MemReqM = 1;
        for (int i = 0; i < 15; i++) step(s);
        s = '0; s.rst = 1; step(s);
        s = '0; s.MemReqM = 1; step(s);
        s.MemAckM = 1; step(s);

        // Random traffic with small register numbers to force frequent matches.
        for (int i = 0; i < 800; i++) begin
            s.rst       = ($urandom_range(0, 99) == 0);
            s.RsD       = 5'($urandom_range(0, 3));
            s.RtD       = 5'($urandom_range(0, 3));
            s.RsE       = 5'($urandom_range(0, 3));
            s.RtE       = 5'($urandom_range(0, 3));
            s.WriteRegE = 5'($urandom_range(0, 3));
            s.WriteRegM = 5'($urandom_range(0, 3));
            s.WriteRegW = 5'($urandom_range(0, 3));
            s.RegWriteE = 1'($urandom);
            s.RegWriteM = 1'($urandom);
            s.RegWriteW = 1'($urandom);
            s.MemtoRegE = ($urandom_range(0, 3) == 0);
            s.MemtoRegM = ($urandom_range(0, 3) == 0);
            s.BranchD   = ($urandom_range(0, 3) == 0);
            s.JumpRD    = ($urandom_range(0, 5) == 0);
            s.PCSrcD    = 1'($urandom);
            s.MDOpD     = ($urandom_range(0, 7) == 0);
            s.HiLoReadD = ($urandom_range(0, 7) == 0);
            s.MDStartE  = ($urandom_range(0, 15) == 0);
            s.MDIsDivE  = 1'($urandom);
            s.MemReqM   = ($urandom_range(0, 3) == 0);
            s.MemAckM   = 1'($urandom);
            step(s);
        end
        s = '0;
        step(s);
        drv_done = 1'b1;
    end

    initial begin
        wait (drv_done);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
